// File: rtl/operand_loader_pkg.sv
// Shared ALU front-end definitions: data widths, loader FSM encoding and
// the switch-to-operand sign extension.
package operand_loader_pkg;

    localparam int OPERAND_W = 32;
    localparam int SW_W      = 8;
    localparam int OP_W      = 3;

    // Encodings are visible on the board LEDs, so they are pinned explicitly.
    typedef enum logic [1:0] {
        GET_A = 2'd0,
        GET_B = 2'd1,
        ISSUE = 2'd2,
        HOLD  = 2'd3
    } loader_state_e;

    function automatic logic [OPERAND_W-1:0] sign_extend(input logic [SW_W-1:0] v);
        return {{(OPERAND_W-SW_W){v[SW_W-1]}}, v};
    endfunction

endpackage

// File: rtl/operand_loader_btn_debounce.sv
// Push-button conditioner: synchronizer chain, stability counter and a
// one-cycle rising-edge pulse on the debounced level.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int SYNC_STAGES     = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic press
);

    localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic [CNT_W-1:0]       r_cnt;
    logic                   r_level;
    logic                   r_press;

    logic w_synced;
    logic w_differ;
    logic w_toggle;

    assign w_synced = r_sync[SYNC_STAGES-1];
    assign w_differ = (w_synced != r_level);
    assign w_toggle = w_differ && (r_cnt == CNT_LAST);
    assign press    = r_press;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync  <= '0;
            r_cnt   <= '0;
            r_level <= 1'b0;
            r_press <= 1'b0;
        end else begin
            // NOTE: every flop here uses <=, so each stage samples its
            // predecessor's pre-edge value and the chain really is SYNC_STAGES deep.
            r_sync[0] <= btn_raw;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end

            // Any agreeing cycle restarts the stability window.
            if (!w_differ || w_toggle) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end

            if (w_toggle) begin
                r_level <= ~r_level;
            end
            r_press <= w_toggle && !r_level;
        end
    end

endmodule

// File: rtl/operand_loader.sv
// Collects operand A, operand B and the opcode from board switches, one
// debounced button press per step, then issues them to the ALU.
module operand_loader
    import operand_loader_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int SYNC_STAGES     = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 btn,
    input  logic [SW_W-1:0]      sw,
    input  logic [OP_W-1:0]      op_sw,
    output logic [OPERAND_W-1:0] a_out,
    output logic [OPERAND_W-1:0] b_out,
    output logic [OP_W-1:0]      op_out,
    output logic                 valid,
    output logic [1:0]           state_led
);

    logic w_press;
    logic w_cap_a;
    logic w_cap_b;

    loader_state_e r_state;
    loader_state_e w_next_state;

    logic [OPERAND_W-1:0] r_a;
    logic [OPERAND_W-1:0] r_b;
    logic [OP_W-1:0]      r_op;

    btn_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .SYNC_STAGES     (SYNC_STAGES)
    ) u_debounce (
        .clk     (clk),
        .rst     (rst),
        .btn_raw (btn),
        .press   (w_press)
    );

    always_comb begin
        // NOTE: defaults first so no path through the case leaves a
        // signal unassigned, which would otherwise infer a latch.
        w_next_state = r_state;
        w_cap_a      = 1'b0;
        w_cap_b      = 1'b0;
        case (r_state)
            GET_A, HOLD: if (w_press) begin
                w_cap_a      = 1'b1;
                w_next_state = GET_B;
            end
            GET_B: if (w_press) begin
                w_cap_b      = 1'b1;
                w_next_state = ISSUE;
            end
            ISSUE:   w_next_state = HOLD;
            default: w_next_state = GET_A;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= GET_A;
        end else begin
            r_state <= w_next_state;
        end
    end

    // B and the opcode deliberately survive a re-load of A from HOLD.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a  <= '0;
            r_b  <= '0;
            r_op <= '0;
        end else begin
            if (w_cap_a) begin
                r_a <= sign_extend(sw);
            end
            if (w_cap_b) begin
                r_b  <= sign_extend(sw);
                r_op <= op_sw;
            end
        end
    end

    assign a_out     = r_a;
    assign b_out     = r_b;
    assign op_out    = r_op;
    assign valid     = (r_state == ISSUE);
    assign state_led = r_state;

endmodule
